// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues reads to the instruction cache and
// buffers the cache's registered {instr, pc} output in a small FIFO for decode.
module fetch_unit #(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [15:0] RESET_PC   = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [15:0] branch_target,
    input  logic [15:0] icache_rd_out,
    input  logic [15:0] icache_pc_out,
    output logic [15:0] icache_rd_dest,
    output logic        icache_rd_en,
    output logic        icache_nop,
    output logic [15:0] inst_out,
    output logic [15:0] inst_pc,
    output logic        inst_valid
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic [15:0]   pc_q, pc_d;
    logic          inflight_q, inflight_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;

    logic [15:0]   instr_mem [FIFO_DEPTH];
    logic [15:0]   pc_mem    [FIFO_DEPTH];

    logic [CW-1:0] occupancy;
    logic          issue;
    logic          push;
    logic          pop;

    // Cache contract: an issue in cycle N returns its data on icache_rd_out in N+1.
    // Issue is throttled so buffered plus in-flight never exceeds the FIFO depth.
    always_comb begin
        occupancy = count_q + {{PW{1'b0}}, inflight_q};
        issue     = !rst && !branch_taken && (occupancy < CW'(FIFO_DEPTH));
        push      = inflight_q && !branch_taken;
        pop       = (count_q != '0) && !stall && !branch_taken;

        pc_d       = pc_q;
        inflight_d = 1'b0;
        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;

        if (branch_taken) begin
            pc_d     = branch_target;
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            if (issue) begin
                pc_d       = pc_q + 16'd1;
                inflight_d = 1'b1;
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            inflight_q <= 1'b0;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            pc_q       <= pc_d;
            inflight_q <= inflight_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
        end
    end

    // Storage is deliberately unreset; the head is gated by count instead.
    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[wr_ptr_q] <= icache_rd_out;
            pc_mem[wr_ptr_q]    <= icache_pc_out;
        end
    end

    assign icache_rd_dest = pc_q;
    assign icache_rd_en   = issue;
    assign icache_nop     = rst || branch_taken;
    assign inst_valid     = (count_q != '0);
    assign inst_out       = inst_valid ? instr_mem[rd_ptr_q] : 16'h0000;
    assign inst_pc        = inst_valid ? pc_mem[rd_ptr_q]    : 16'h0000;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: queue-based fetch model plus a registered cache model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        branch_taken;
    logic [15:0] branch_target;

    logic [15:0] a_rd_out, a_pc_out, a_dest, a_inst, a_pc;
    logic        a_en, a_nop, a_valid;
    logic [15:0] b_rd_out, b_pc_out, b_dest, b_inst, b_pc;
    logic        b_en, b_nop, b_valid;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_q[$];
    logic [15:0] m_pc;
    logic [15:0] m_pend;
    bit          m_infl;

    fetch_unit #(.FIFO_DEPTH(4), .RESET_PC(16'h0000)) dut_a (
        .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
        .branch_target(branch_target), .icache_rd_out(a_rd_out), .icache_pc_out(a_pc_out),
        .icache_rd_dest(a_dest), .icache_rd_en(a_en), .icache_nop(a_nop),
        .inst_out(a_inst), .inst_pc(a_pc), .inst_valid(a_valid)
    );

    fetch_unit #(.FIFO_DEPTH(4), .RESET_PC(16'hFFFE)) dut_b (
        .clk(clk), .rst(rst), .stall(1'b0), .branch_taken(1'b0),
        .branch_target(16'h0000), .icache_rd_out(b_rd_out), .icache_pc_out(b_pc_out),
        .icache_rd_dest(b_dest), .icache_rd_en(b_en), .icache_nop(b_nop),
        .inst_out(b_inst), .inst_pc(b_pc), .inst_valid(b_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] cache_word(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h5A3C;
    endfunction

    // Registered instruction cache models
    always @(posedge clk) begin
        if (a_nop) begin
            a_rd_out <= 16'h0000;
            a_pc_out <= 16'h0000;
        end else if (a_en) begin
            a_rd_out <= cache_word(a_dest);
            a_pc_out <= a_dest;
        end
    end

    always @(posedge clk) begin
        if (b_nop) begin
            b_rd_out <= 16'h0000;
            b_pc_out <= 16'h0000;
        end else if (b_en) begin
            b_rd_out <= cache_word(b_dest);
            b_pc_out <= b_dest;
        end
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_pc   = 16'h0000;
        m_pend = 16'h0000;
        m_infl = 1'b0;
    endtask

    // One clock cycle: drive at negedge, compare against the model, advance the model.
    task automatic step(input bit r, input bit s, input bit b, input logic [15:0] t, input bit ar);
        bit          exp_en;
        bit          do_issue;
        logic [31:0] head;
        @(negedge clk);
        rst           = r;
        stall         = s;
        branch_taken  = b;
        branch_target = t;
        #1;
        do_issue = (exp_q.size() + int'(m_infl)) < 4;
        exp_en   = !r && !b && do_issue;
        head     = (exp_q.size() != 0) ? exp_q[0] : 32'h0;
        chk("rd_en", 16'(a_en), 16'(exp_en));
        chk("rd_dest", a_dest, m_pc);
        chk("nop", 16'(a_nop), 16'(r || b));
        chk("inst_valid", 16'(a_valid), 16'(exp_q.size() != 0));
        chk("inst_out", a_inst, head[31:16]);
        chk("inst_pc", a_pc, head[15:0]);
        if (ar) begin
            #2 rst = 1'b1;
            #1;
            chk("async_rst_valid", 16'(a_valid), 16'h0000);
            chk("async_rst_en", 16'(a_en), 16'h0000);
            chk("async_rst_nop", 16'(a_nop), 16'h0001);
            chk("async_rst_dest", a_dest, 16'h0000);
            model_reset();
        end else if (r) begin
            model_reset();
        end else if (b) begin
            exp_q.delete();
            m_pc   = t;
            m_infl = 1'b0;
        end else begin
            if (exp_q.size() != 0 && !s) void'(exp_q.pop_front());
            if (m_infl) exp_q.push_back({cache_word(m_pend), m_pend});
            if (do_issue) begin
                m_pend = m_pc;
                m_pc   = m_pc + 16'd1;
                m_infl = 1'b1;
            end else begin
                m_infl = 1'b0;
            end
        end
    endtask

    logic [15:0] wrap_exp [4];
    int          rst_hold;

    initial begin
        rst           = 1'b1;
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 16'h0000;
        wrap_exp      = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
        model_reset();

        step(1, 0, 0, 16'h0, 0);
        chk("reset_valid", 16'(a_valid), 16'h0000);
        chk("reset_en", 16'(a_en), 16'h0000);
        chk("reset_nop", 16'(a_nop), 16'h0001);
        chk("reset_inst", a_inst, 16'h0000);
        chk("reset_dest_b", b_dest, 16'hFFFE);
        step(1, 0, 0, 16'h0, 0);

        // Straight-line fetch after release
        for (int k = 0; k < 12; k++) begin
            step(0, 0, 0, 16'h0, 0);
            chk("straight_dest", a_dest, 16'(k));
            chk("straight_valid", 16'(a_valid), 16'(k >= 2));
            if (k >= 2) chk("straight_pc", a_pc, 16'(k - 2));
            if (k >= 2 && k <= 5) chk("wrap_pc_b", b_pc, wrap_exp[k - 2]);
        end

        // Six-cycle stall: head held at PC 10, issue stops once four are owned
        for (int i = 0; i < 6; i++) begin
            step(0, 1, 0, 16'h0, 0);
            chk("stall_head", a_pc, 16'h000A);
            if (i == 0) chk("stall_en_early", 16'(a_en), 16'h0001);
            if (i >= 2) chk("stall_en_full", 16'(a_en), 16'h0000);
        end
        step(0, 0, 0, 16'h0, 0);
        chk("release_head", a_pc, 16'h000A);

        // Branch with three entries buffered
        step(0, 0, 1, 16'h0040, 0);
        chk("br_nop", 16'(a_nop), 16'h0001);
        chk("br_en", 16'(a_en), 16'h0000);
        chk("br_head", a_pc, 16'h000B);
        step(0, 0, 0, 16'h0, 0);
        chk("br_next_valid", 16'(a_valid), 16'h0000);
        chk("br_next_dest", a_dest, 16'h0040);
        chk("br_next_nop", 16'(a_nop), 16'h0000);
        step(0, 0, 0, 16'h0, 0);
        step(0, 0, 0, 16'h0, 0);
        chk("br_target_pc", a_pc, 16'h0040);
        step(0, 0, 0, 16'h0, 0);
        chk("br_target_pc1", a_pc, 16'h0041);

        // Branch while stalled with a full FIFO
        for (int i = 0; i < 6; i++) step(0, 1, 0, 16'h0, 0);
        step(0, 1, 1, 16'h0100, 0);
        chk("full_br_valid", 16'(a_valid), 16'h0001);
        chk("full_br_en", 16'(a_en), 16'h0000);
        step(0, 1, 0, 16'h0, 0);
        chk("full_br_empty", 16'(a_valid), 16'h0000);
        chk("full_br_dest", a_dest, 16'h0100);
        step(0, 0, 0, 16'h0, 0);
        step(0, 0, 0, 16'h0, 0);
        chk("full_br_target_pc", a_pc, 16'h0100);

        // Asynchronous reset mid-stream
        for (int i = 0; i < 3; i++) step(0, 0, 0, 16'h0, 0);
        step(0, 0, 0, 16'h0, 1);
        step(1, 0, 0, 16'h0, 0);
        for (int k = 0; k < 4; k++) begin
            step(0, 0, 0, 16'h0, 0);
            if (k == 2) chk("post_rst_pc", a_pc, 16'h0000);
            if (k == 3) chk("post_rst_pc1", a_pc, 16'h0001);
        end

        // Randomized traffic
        rst_hold = 0;
        for (int n = 0; n < 3000; n++) begin
            bit          s;
            bit          b;
            logic [15:0] t;
            s = ($urandom_range(0, 9) < 4);
            b = ($urandom_range(0, 99) < 7);
            t = ($urandom_range(0, 3) == 0) ? 16'hFFFD : 16'($urandom);
            if (rst_hold > 0) begin
                step(1, s, b, t, 0);
                rst_hold--;
            end else if ($urandom_range(0, 199) == 0) begin
                step(0, s, b, t, 1);
                rst_hold = $urandom_range(1, 3);
            end else begin
                step(0, s, b, t, 0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage sitting directly upstream of the instruction cache. It owns the program counter, drives the cache's read address, enable and nop inputs, and captures the cache's registered instruction/PC output into a small FIFO. The FIFO absorbs decode stalls and in-flight fetches so that no instruction is lost or duplicated. Taken branches from downstream redirect the PC, flush the FIFO and squash the in-flight fetch.

## Interface
- FIFO_DEPTH, 4, instruction buffer entries; power of two, minimum 4.
- RESET_PC, 16'h0000, PC value loaded by reset.

- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  decode does not accept the head instruction this cycle.
- branch_taken  in  1  single-cycle redirect request.
- branch_target  in  16  new PC, valid with branch_taken.
- icache_rd_out  in  16  cache instruction output; valid the cycle after an issue.
- icache_pc_out  in  16  cache PC output, paired with icache_rd_out.
- icache_rd_dest  out  16  cache read address; always equals the PC register.
- icache_rd_en  out  1  cache read enable (issue).
- icache_nop  out  1  forces the cache output to 16'h0000 at the next edge.
- inst_out  out  16  FIFO head instruction; 16'h0000 when empty.
- inst_pc  out  16  FIFO head PC; 16'h0000 when empty.
- inst_valid  out  1  FIFO non-empty.

## Operation
- State:
  - pc: 16 bits.
  - inflight: 1 bit; set when the cache output arriving this cycle belongs to an issue from the previous cycle.
  - FIFO: count (0..FIFO_DEPTH), rd_ptr and wr_ptr. Each entry holds {instr, pc}.
- Issue: icache_rd_en = !rst && !branch_taken && (count + inflight < FIFO_DEPTH).
  - On issue, pc <= pc + 1, modulo 2^16 (16'hFFFF wraps to 16'h0000).
  - On issue, inflight <= 1; otherwise inflight <= 0.
- Push: when inflight==1 and !branch_taken, write {icache_rd_out, icache_pc_out} at wr_ptr.
- Pop: when inst_valid && !stall && !branch_taken, advance rd_ptr.
- Push and pop in the same cycle leave count unchanged. The issue rule guarantees the FIFO never overflows.
- Pointers wrap modulo FIFO_DEPTH.
- Redirect (branch_taken=1) has priority over issue, push, pop and stall:
  - pc <= branch_target.
  - count, rd_ptr and wr_ptr <= 0.
  - inflight <= 0; the arriving cache data is discarded.
  - icache_rd_en=0.
- icache_nop = rst || branch_taken (combinational).
- inst_out/inst_pc read combinationally from the FIFO head and are gated to 0 when count==0. FIFO storage is not reset.
- Reset (async, immediate): pc=RESET_PC, inflight=0, count=0, pointers 0. Resulting outputs:
  - inst_valid=0, inst_out=0, inst_pc=0.
  - icache_rd_en=0, icache_nop=1, icache_rd_dest=RESET_PC.

## Timing
- Fetch latency is 2 cycles:
  - Cycle N: issue to address A.
  - Cycle N+1: cache output valid, push at end of cycle.
  - Cycle N+2: A appears at the FIFO head, provided older entries have drained.
- First issue happens in the first cycle after rst deasserts. First inst_valid is 2 cycles later.
- Steady state with stall=0 delivers one instruction per cycle, with consecutive PCs and no bubbles.
- Stall:
  - The head is held stable.
  - Issues continue until count + inflight reaches FIFO_DEPTH, then icache_rd_en drops.
  - After release, the head pops in the same cycle and issue resumes in the same cycle its condition holds.
- Branch:
  - In the branch cycle, icache_nop=1 and icache_rd_en=0.
  - In the next cycle, icache_rd_dest=branch_target and an issue occurs (branch_taken low).
  - The target instruction is valid 2 cycles after its issue.
- Branch while stalled, or while the FIFO is full, follows the same redirect rule.
- Back-to-back branch_taken: the last target wins, and no issue happens while branch_taken is high.
- Reset mid-stream discards all in-flight and buffered instructions.

## Test plan
- Straight line, RESET_PC=0, stall=0: icache_rd_dest=0,1,2,... every cycle; inst_valid rises 2 cycles after reset release; inst_pc=0,1,2,... with no gaps.
- Stall 6 cycles mid-stream: inst_out/inst_pc held. icache_rd_en=0 once count + inflight = 4. On release, PCs continue consecutively with no duplicate or missing PC.
- branch_taken, target 16'h0040, with 3 entries buffered: the next cycle shows inst_valid=0 and icache_rd_dest=16'h0040. icache_nop=1 only in the branch cycle. The next valid inst_pc is 16'h0040, followed by 16'h0041, and no stale PCs appear.
- branch_taken while stall=1 and the FIFO is full: redirect still occurs, the FIFO is empty the next cycle, and fetch restarts at the target.
- RESET_PC=16'hFFFE: inst_pc sequence is FFFE, FFFF, 0000, 0001.
- Assert rst asynchronously between edges mid-stream: inst_valid=0 and icache_rd_en=0 immediately. After release, fetch restarts at RESET_PC with no pre-reset instruction delivered.
